// File: rtl/uc_control_if.sv
// Datapath-side bundle for the microcontroller sequencing control unit.
// master = datapath (opcode, z); slave = uc_control (selects and enables).
interface uc_control_if;
   logic [5:0] opcode;
   logic       z;
   logic       s_inc;
   logic       s_inm;
   logic       we3;
   logic [2:0] op;
   logic       pc_en;
   logic       z_en;

   modport master (
      output opcode, z,
      input  s_inc, s_inm, we3, op, pc_en, z_en
   );

   modport slave (
      input  opcode, z,
      output s_inc, s_inm, we3, op, pc_en, z_en
   );
endinterface

// File: rtl/uc_control.sv
// Sequencing control for the single-cycle 8-bit datapath: decode, run/hold/halt, icount.
// Optional single-step port when UC_STEP_EN is defined.
module uc_control #(
   parameter int CNT_W    = 16,
   parameter int ILL_HALT = 0
) (
   input  logic             clk,
   input  logic             reset,
`ifdef UC_STEP_EN
   input  logic             step,
`endif
   input  logic             start,
   input  logic             hold,
   uc_control_if.slave      dp,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] icount
);

   typedef enum logic [1:0] {
      S_IDLE, S_RUN, S_HOLD, S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ill_q, ill_d;

   logic [3:0] fn;
   logic       is_alu, is_li, is_j, is_jz, is_jnz, is_halt, is_ill;
   logic       halt_go, exec, skip, retire;
   logic       s_inc, s_inm, we3, pc_en, z_en;
   logic [2:0] op;
   logic       unused_opc;

   assign fn         = dp.opcode[3:0];
   assign unused_opc = ^dp.opcode[5:4];

   assign is_alu  = ~fn[3];
   assign is_li   = (fn == 4'b1000);
   assign is_j    = (fn == 4'b1001);
   assign is_jz   = (fn == 4'b1010);
   assign is_jnz  = (fn == 4'b1011);
   assign is_halt = (fn == 4'b1111);
   assign is_ill  = (fn == 4'b1101) | (fn == 4'b1110);

   // An illegal opcode stops the core only when ILL_HALT is set
   assign halt_go = is_halt | (is_ill & (ILL_HALT != 0));

   always_comb begin
      state_d = state_q;
      exec    = 1'b0;
      skip    = 1'b0;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (hold) state_d = S_HOLD;
            else      exec    = 1'b1;
         end
         S_HOLD: begin
`ifdef UC_STEP_EN
            if (step)       exec    = 1'b1;
            else if (!hold) state_d = S_RUN;
`else
            if (!hold) state_d = S_RUN;
`endif
         end
         S_HALT: begin
            if (start) begin
               skip    = 1'b1;
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (exec && halt_go) state_d = S_HALT;
   end

   always_comb begin
      s_inc = 1'b1;
      s_inm = 1'b0;
      we3   = 1'b0;
      op    = 3'b000;
      pc_en = 1'b0;
      z_en  = 1'b0;
      if (exec) begin
         unique case (1'b1)
            is_alu: begin
               op   = fn[2:0];
               we3  = 1'b1;
               z_en = 1'b1;
            end
            is_li: begin
               we3   = 1'b1;
               s_inm = 1'b1;
            end
            is_j:    s_inc = 1'b0;
            is_jz:   s_inc = ~dp.z;
            is_jnz:  s_inc = dp.z;
            default: s_inc = 1'b1;
         endcase
         pc_en = ~halt_go;
      end
      // Leaving HALT steps past the HALT instruction without retiring it
      if (skip) pc_en = 1'b1;
   end

   assign retire = exec & ~halt_go;
   assign cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
   assign ill_d  = ill_q | (exec & is_ill);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
      end
   end

   assign dp.s_inc = s_inc;
   assign dp.s_inm = s_inm;
   assign dp.we3   = we3;
   assign dp.op    = op;
   assign dp.pc_en = pc_en;
   assign dp.z_en  = z_en;

   assign halted  = (state_q == S_HALT);
   assign illegal = ill_q;
   assign icount  = cnt_q;
endmodule

// File: tb/tb_uc_control.sv
// Bench for uc_control: two instances (ILL_HALT=0/1) against a behavioural model.
// Directed steps for each scenario, then a randomized run.
module tb_uc_control;
   localparam int CW = 4;
   localparam int MOD = 1 << CW;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HELD = 2;
   localparam int M_HALT = 3;

   logic clk, reset, start, hold;
`ifdef UC_STEP_EN
   logic step;
`endif
   logic [5:0] opcode;
   logic       z;
   logic       halted [2];
   logic       illegal [2];
   logic [CW-1:0] icount [2];

   uc_control_if ifa ();
   uc_control_if ifb ();

   assign ifa.opcode = opcode;
   assign ifa.z      = z;
   assign ifb.opcode = opcode;
   assign ifb.z      = z;

   uc_control #(.CNT_W(CW), .ILL_HALT(0)) u_dut0 (
      .clk(clk), .reset(reset),
`ifdef UC_STEP_EN
      .step(step),
`endif
      .start(start), .hold(hold), .dp(ifa.slave),
      .halted(halted[0]), .illegal(illegal[0]), .icount(icount[0])
   );

   uc_control #(.CNT_W(CW), .ILL_HALT(1)) u_dut1 (
      .clk(clk), .reset(reset),
`ifdef UC_STEP_EN
      .step(step),
`endif
      .start(start), .hold(hold), .dp(ifb.slave),
      .halted(halted[1]), .illegal(illegal[1]), .icount(icount[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_asrt = 0;
   int n_fail = 0;

   int mode [2];
   int cnt  [2];
   bit ill  [2];
   int nmode [2];
   bit ret  [2];
   bit ilev [2];

   function automatic logic [7:0] obs_dec(input int k);
      if (k == 0)
         return {ifa.s_inc, ifa.s_inm, ifa.we3, ifa.op, ifa.pc_en, ifa.z_en};
      return {ifb.s_inc, ifb.s_inm, ifb.we3, ifb.op, ifb.pc_en, ifb.z_en};
   endfunction

   task automatic chk(input string tag, input int k,
                      input logic [7:0] o, input logic [7:0] e);
      n_asrt++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s dut%0d t=%0t observed=%b expected=%b",
                tag, k, $time, o, e);
      end
   endtask

   // Expected selects/enables for the current inputs, plus the model's next mode
   function automatic logic [7:0] model(input int k);
      int  c;
      bit  ex, hlt, sinc, sinm, w, pe, ze;
      logic [2:0] o;
      c    = int'(opcode[3:0]);
      ex   = (mode[k] == M_RUN) && !hold;
`ifdef UC_STEP_EN
      if (mode[k] == M_HELD && step) ex = 1'b1;
`endif
      sinc = 1; sinm = 0; w = 0; o = 3'd0; pe = 0; ze = 0;
      ret[k]   = 0;
      ilev[k]  = 0;
      nmode[k] = mode[k];
      if (ex) begin
         hlt = 0;
         if (c < 8) begin
            o = 3'(c % 8); w = 1; ze = 1;
         end else if (c == 8) begin
            w = 1; sinm = 1;
         end else if (c == 9) sinc = 0;
         else if (c == 10) sinc = !z;
         else if (c == 11) sinc = z;
         else if (c == 15) hlt = 1;
         else if (c == 13 || c == 14) begin
            ilev[k] = 1;
            hlt = (k == 1);
         end
         if (hlt) nmode[k] = M_HALT;
         else begin
            pe = 1;
            ret[k] = 1;
         end
      end else begin
         if (mode[k] == M_IDLE && start) nmode[k] = M_RUN;
         if (mode[k] == M_RUN && hold) nmode[k] = M_HELD;
`ifdef UC_STEP_EN
         if (mode[k] == M_HELD && !hold && !step) nmode[k] = M_RUN;
`else
         if (mode[k] == M_HELD && !hold) nmode[k] = M_RUN;
`endif
         if (mode[k] == M_HALT && start) begin
            nmode[k] = M_RUN;
            pe = 1;
         end
      end
      return {sinc, sinm, w, o, pe, ze};
   endfunction

   function automatic logic [7:0] reg_exp(input int k);
      return {2'b00, (mode[k] == M_HALT), ill[k], 4'(cnt[k])};
   endfunction

   function automatic logic [7:0] reg_obs(input int k);
      return {2'b00, halted[k], illegal[k], icount[k]};
   endfunction

   // Called at posedge+1 with inputs already set
   task automatic tick(input string tag);
      logic [7:0] e [2];
      #3;
      for (int k = 0; k < 2; k++) begin
         e[k] = model(k);
         chk({tag, "/dec"}, k, obs_dec(k), e[k]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         mode[k] = nmode[k];
         if (ret[k]) cnt[k] = (cnt[k] + 1) % MOD;
         if (ilev[k]) ill[k] = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++)
         chk({tag, "/reg"}, k, reg_obs(k), reg_exp(k));
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mode[k] = M_IDLE;
         cnt[k]  = 0;
         ill[k]  = 1'b0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk({tag, "/dec"}, k, obs_dec(k), 8'b1000_0000);
         chk({tag, "/reg"}, k, reg_obs(k), reg_exp(k));
      end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; hold = 1'b0;
      opcode = 6'd0; z = 1'b0;
`ifdef UC_STEP_EN
      step = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
         mode[k] = M_IDLE; cnt[k] = 0; ill[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("por/dec", k, obs_dec(k), 8'b1000_0000);
         chk("por/reg", k, reg_obs(k), reg_exp(k));
      end
      reset = 1'b1;

      start = 1'b1; tick("start");
      start = 1'b0;
      opcode = 6'b110011; tick("alu3");
      for (int i = 0; i < 4; i++) tick("alu_run");
      async_reset("rst_mid_run");

      start = 1'b1; tick("restart");
      start = 1'b0;
      opcode = 6'b001010; z = 1'b1; tick("jz_z1");
      z = 1'b0; tick("jz_z0");
      opcode = 6'b001011; tick("jnz_z0");
      opcode = 6'b001001; tick("j");
      opcode = 6'b001000; tick("li");

      opcode = 6'b000101; hold = 1'b1;
      for (int i = 0; i < 3; i++) tick("hold");
      hold = 1'b0;
      tick("hold_release");
      tick("hold_exec");

      opcode = 6'b001101; tick("illegal");
      opcode = 6'b001100; tick("nop_after_ill");
      opcode = 6'b001111; tick("halt");
      opcode = 6'b000001; tick("halted_wait");
      start = 1'b1; tick("halt_skip");
      start = 1'b0; tick("after_skip");

      for (int i = 0; i < MOD + 3; i++) begin
         opcode = 6'(i % 8);
         tick("wrap");
      end

`ifdef UC_STEP_EN
      hold = 1'b1; opcode = 6'b000010; tick("to_hold");
      step = 1'b1; tick("step");
      step = 1'b0; tick("step_off");
      hold = 1'b0; tick("step_release");
`endif

      for (int i = 0; i < 500; i++) begin
         opcode = 6'($urandom);
         z      = 1'($urandom);
         hold   = ($urandom_range(0, 3) == 0);
         start  = ($urandom_range(0, 9) == 0);
`ifdef UC_STEP_EN
         step   = ($urandom_range(0, 4) == 0);
`endif
         if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
         else tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end
endmodule
